// File: rtl/uart_pkg.sv
// Shared UART types and constants: transmit-queue FSM states and data widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

  typedef enum logic [2:0] {
    TXQ_IDLE,
    TXQ_LOAD,
    TXQ_KICK,
    TXQ_WAIT_LO,
    TXQ_WAIT_HI
  } txq_state_t;

  localparam int TXQ_DEPTH_DEF = 16;
  localparam int UART_DATA_W   = 32;

endpackage

// File: rtl/txq_fifo_mem.sv
// DEPTH x 8 byte queue storage with read/write pointers, level, full/empty and sticky overflow.
// Latency: a push is visible at rd_data/level the cycle after wr_en; rd_data is a combinational read of the head.
// Backpressure: pushes while full are dropped and flagged; pops while empty are ignored.
// Ports: clk, rst_n (async active-low); wr_en/wr_data push side; rd_en pop; clr_ovf clears overflow;
//        rd_data head byte; full, empty, level (AW+1 bits), overflow (sticky drop flag).
module txq_fifo_mem
  import uart_pkg::*;
#(
  parameter  int DEPTH = TXQ_DEPTH_DEF,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en,
  input  logic [7:0]   wr_data,
  input  logic         rd_en,
  input  logic         clr_ovf,
  output logic [7:0]   rd_data,
  output logic         full,
  output logic         empty,
  output logic [AW:0]  level,
  output logic         overflow
);

  logic [7:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          overflow_q, overflow_d;
  logic          push, pop;

  assign full  = (level_q == (AW+1)'(DEPTH));
  assign empty = (level_q == '0);

  // full is the registered level, so a write while full is dropped even if a pop happens this cycle.
  assign push = wr_en && !full;
  assign pop  = rd_en && !empty;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push && !pop)      level_d = level_q + (AW+1)'(1);
    else if (pop && !push) level_d = level_q - (AW+1)'(1);
    // A new drop outranks a same-cycle clear.
    if (wr_en && full)  overflow_d = 1'b1;
    else if (clr_ovf)   overflow_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is not reset: clearing the pointers and level is enough to discard contents.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data  = mem_q[rd_ptr_q];
  assign level    = level_q;
  assign overflow = overflow_q;

endmodule

// File: rtl/uart_tx_queue.sv
// Byte transmit queue feeding the UART: buffers MMIO byte stores and hands them out one frame at a time.
// Latency: push into an empty idle queue -> data_we 2 cycles later, trmt 3 cycles later; 1 cycle from tx_done rise to next data_we.
// Backpressure: pushes while full are dropped (sticky overflow); baud_we holds the load cycle; tx_done paces frames.
// Ports: clk, rst_n (async active-low); wr_en/wr_data push; tx_en start enable; baud_we UART baud strobe copy;
//        clr_ovf; full/empty/level/overflow queue status; busy; data_we/data_tx/trmt to UART; tx_done from UART;
//        txq_low (low-watermark flag) present only when UART_TXQ_LOWMARK_EN is defined.
module uart_tx_queue
  import uart_pkg::*;
#(
  parameter  int DEPTH     = TXQ_DEPTH_DEF,
`ifdef UART_TXQ_LOWMARK_EN
  parameter  int LOW_WMARK = 4,
`endif
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [7:0]             wr_data,
  input  logic                   tx_en,
  input  logic                   baud_we,
  input  logic                   clr_ovf,
  output logic                   full,
  output logic                   empty,
  output logic [AW:0]            level,
  output logic                   overflow,
  output logic                   busy,
  output logic                   data_we,
  output logic [UART_DATA_W-1:0] data_tx,
  output logic                   trmt,
`ifdef UART_TXQ_LOWMARK_EN
  output logic                   txq_low,
`endif
  input  logic                   tx_done
);

  txq_state_t state_q, state_d;
  logic       pop;
  logic [7:0] head;

  txq_fifo_mem #(.DEPTH(DEPTH)) u_mem (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .rd_en    (pop),
    .clr_ovf  (clr_ovf),
    .rd_data  (head),
    .full     (full),
    .empty    (empty),
    .level    (level),
    .overflow (overflow)
  );

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      TXQ_IDLE:    if (!empty && tx_en) state_d = TXQ_LOAD;
      // The UART services baud_we first, so the byte write must wait it out.
      TXQ_LOAD:    if (!baud_we) begin
                     pop     = 1'b1;
                     state_d = TXQ_KICK;
                   end
      TXQ_KICK:    state_d = TXQ_WAIT_LO;
      // The UART registers trmt, so the previous frame's tx_done lingers 1-2 cycles.
      TXQ_WAIT_LO: if (!tx_done) state_d = TXQ_WAIT_HI;
      TXQ_WAIT_HI: if (tx_done) state_d = (!empty && tx_en) ? TXQ_LOAD : TXQ_IDLE;
      default:     state_d = TXQ_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= TXQ_IDLE;
    else        state_q <= state_d;
  end

  assign busy    = (state_q != TXQ_IDLE);
  assign data_we = (state_q == TXQ_LOAD) && !baud_we;
  assign trmt    = (state_q == TXQ_KICK);
  assign data_tx = (state_q == TXQ_LOAD) ? {{(UART_DATA_W-8){1'b0}}, head} : '0;

`ifdef UART_TXQ_LOWMARK_EN
  logic txq_low_q, txq_low_d;

  assign txq_low_d = (level <= (AW+1)'(LOW_WMARK));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) txq_low_q <= 1'b1;
    else        txq_low_q <= txq_low_d;
  end

  assign txq_low = txq_low_q;
`endif

endmodule

// File: tb/tb_uart_tx_queue.sv
module tb_uart_tx_queue;

  localparam int DEPTH = 16;
  localparam int FRAME = 50;
  localparam int LOWM  = 4;

  logic        clk, rst_n, wr_en, tx_en, baud_we, clr_ovf, tx_done;
  logic [7:0]  wr_data;
  logic        full, empty, overflow, busy, data_we, trmt;
  logic [4:0]  level;
  logic [31:0] data_tx;
`ifdef UART_TXQ_LOWMARK_EN
  logic        txq_low;
`endif

  int n_chk = 0;
  int n_err = 0;

  uart_tx_queue dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .tx_en    (tx_en),
    .baud_we  (baud_we),
    .clr_ovf  (clr_ovf),
    .full     (full),
    .empty    (empty),
    .level    (level),
    .overflow (overflow),
    .busy     (busy),
    .data_we  (data_we),
    .data_tx  (data_tx),
    .trmt     (trmt),
`ifdef UART_TXQ_LOWMARK_EN
    .txq_low  (txq_low),
`endif
    .tx_done  (tx_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  // UART stand-in: tx_done idles high, falls 2 cycles after trmt, stays low for FRAME cycles.
  int ucnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_done <= 1'b1;
      ucnt    <= 0;
    end else if (trmt) begin
      ucnt <= FRAME + 2;
    end else if (ucnt > 0) begin
      ucnt <= ucnt - 1;
      if (ucnt == FRAME + 1) tx_done <= 1'b0;
      if (ucnt == 1)         tx_done <= 1'b1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a byte queue in push order plus the sticky flag and watermark bit.
  logic [7:0] mq[$];
  logic [7:0] sent_q[$];
  logic       m_ovf, m_low, prev_we, prev_done, gap_pend, full_m;

  always @(negedge clk) begin
    if (!rst_n) begin
      mq.delete();
      m_ovf = 1'b0; m_low = 1'b1; prev_we = 1'b0; prev_done = 1'b1; gap_pend = 1'b0;
      chk("rst_level", 32'(level), 0);
      chk("rst_empty", 32'(empty), 1);
      chk("rst_full", 32'(full), 0);
      chk("rst_overflow", 32'(overflow), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_data_we", 32'(data_we), 0);
      chk("rst_trmt", 32'(trmt), 0);
      chk("rst_data_tx", data_tx, 0);
`ifdef UART_TXQ_LOWMARK_EN
      chk("rst_txq_low", 32'(txq_low), 1);
`endif
    end else begin
      chk("level", 32'(level), 32'(mq.size()));
      chk("full", 32'(full), 32'(mq.size() == DEPTH));
      chk("empty", 32'(empty), 32'(mq.size() == 0));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("trmt_after_we", 32'(trmt), 32'(prev_we));
`ifdef UART_TXQ_LOWMARK_EN
      chk("txq_low", 32'(txq_low), 32'(m_low));
`endif
      if (gap_pend && !baud_we) chk("gap_after_done", 32'(data_we), 1);
      if (data_we) begin
        chk("we_during_baud", 32'(baud_we), 0);
        if (mq.size() == 0) begin
          n_chk++; n_err++;
          $display("FAIL pop_empty: data_we=1 with model queue empty at %0t", $time);
        end else begin
          chk("data_tx", data_tx, {24'h0, mq[0]});
          sent_q.push_back(data_tx[7:0]);
        end
      end
      // Advance the model across the coming clock edge.
      gap_pend = tx_done && !prev_done && tx_en && (mq.size() != 0);
      m_low    = (mq.size() <= LOWM);
      full_m   = (mq.size() == DEPTH);
      if (wr_en && full_m) m_ovf = 1'b1;
      else if (clr_ovf)    m_ovf = 1'b0;
      if (data_we && mq.size() != 0) void'(mq.pop_front());
      if (wr_en && !full_m) mq.push_back(wr_data);
      prev_we   = data_we;
      prev_done = tx_done;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_n(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      wr_en   = 1'b1;
      wr_data = first + 8'(i);
      step();
    end
    wr_en = 1'b0;
  endtask

  task automatic wait_idle(input int max, input string nm);
    bit ok = 1'b0;
    for (int k = 0; k < max && !ok; k++) begin
      @(negedge clk);
      ok = !busy && (empty || !tx_en);
    end
    n_chk++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: still busy after %0d cycles, want idle", nm, max);
    end
  endtask

  task automatic wait_trmt(input int max, input string nm);
    bit ok = 1'b0;
    for (int k = 0; k < max && !ok; k++) begin
      @(negedge clk);
      ok = trmt;
    end
    n_chk++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: no trmt within %0d cycles, want pulse", nm, max);
    end
  endtask

  int base;

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_data = 8'h00; tx_en = 1'b0; baud_we = 1'b0; clr_ovf = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_empty", 32'(empty), 1);
    chk("reset_level", 32'(level), 0);
    chk("reset_busy", 32'(busy), 0);
    step(); rst_n = 1'b1;
    step();

    // Single byte: data_we 2 cycles after the push cycle, trmt 3 cycles after.
    tx_en = 1'b1;
    push_n(8'h41, 1);
    @(negedge clk);
    chk("single_we_p1", 32'(data_we), 0);
    @(negedge clk);
    chk("single_we_p2", 32'(data_we), 1);
    chk("single_data_tx", data_tx, 32'h0000_0041);
    chk("single_busy", 32'(busy), 1);
    @(negedge clk);
    chk("single_trmt_p3", 32'(trmt), 1);
    chk("single_we_p3", 32'(data_we), 0);
    @(negedge clk);
    chk("single_trmt_p4", 32'(trmt), 0);
    wait_idle(200, "single_done");
    chk("single_empty", 32'(empty), 1);
    chk("single_sent", 32'(sent_q.size()), 1);

    // Burst of 16 into a paused queue, then release.
    step(); tx_en = 1'b0;
    push_n(8'h10, 16);
    @(negedge clk);
    chk("burst_full", 32'(full), 1);
    chk("burst_level", 32'(level), 16);
`ifdef UART_TXQ_LOWMARK_EN
    chk("burst_low", 32'(txq_low), 0);
`endif
    base = sent_q.size();
    step(); tx_en = 1'b1;
    wait_idle(3000, "burst_done");
    chk("burst_count", 32'(sent_q.size() - base), 16);
    chk("burst_first", 32'(sent_q[base]), 32'h10);
    chk("burst_last", 32'(sent_q[base+15]), 32'h1F);

    // Overflow: 17 pushes while paused, then clear.
    step(); tx_en = 1'b0;
    push_n(8'h20, 17);
    @(negedge clk);
    chk("ovf_level", 32'(level), 16);
    chk("ovf_flag", 32'(overflow), 1);
    step(); clr_ovf = 1'b1;
    step(); clr_ovf = 1'b0;
    @(negedge clk);
    chk("ovf_cleared", 32'(overflow), 0);
    // Push while full in the same cycle as the first pop: still dropped.
    step(); tx_en = 1'b1;
    step(); wr_en = 1'b1; wr_data = 8'hEE;
    @(negedge clk);
    chk("fullpop_we", 32'(data_we), 1);
    chk("fullpop_full", 32'(full), 1);
    step(); wr_en = 1'b0;
    @(negedge clk);
    chk("fullpop_ovf", 32'(overflow), 1);
    chk("fullpop_level", 32'(level), 15);
    base = sent_q.size() - 1;
    wait_idle(3000, "fullpop_done");
    chk("fullpop_count", 32'(sent_q.size() - base), 16);
    chk("fullpop_last", 32'(sent_q[sent_q.size()-1]), 32'h2F);
    step(); clr_ovf = 1'b1;
    step(); clr_ovf = 1'b0;

    // Baud collision: baud_we held for 3 cycles of LOAD.
    push_n(8'h55, 1);
    step(); baud_we = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("baud_we_blocked", 32'(data_we), 0);
      chk("baud_level_held", 32'(level), 1);
      chk("baud_busy", 32'(busy), 1);
      step();
      if (i == 2) baud_we = 1'b0;
    end
    @(negedge clk);
    chk("baud_release_we", 32'(data_we), 1);
    chk("baud_data_tx", data_tx, 32'h0000_0055);
    @(negedge clk);
    chk("baud_level_after", 32'(level), 0);
    chk("baud_trmt", 32'(trmt), 1);
    wait_idle(200, "baud_done");

    // Pause: drop tx_en mid-frame; frame completes, remaining bytes retained.
    step(); tx_en = 1'b0;
    push_n(8'h61, 3);
    tx_en = 1'b1;
    wait_trmt(50, "pause_trmt");
    step(); tx_en = 1'b0;
    wait_idle(200, "pause_park");
    chk("pause_busy", 32'(busy), 0);
    chk("pause_level", 32'(level), 2);
    repeat (20) @(negedge clk);
    chk("pause_still_idle", 32'(busy), 0);
    chk("pause_retained", 32'(level), 2);
    chk("pause_last_sent", 32'(sent_q[sent_q.size()-1]), 32'h61);
`ifdef UART_TXQ_LOWMARK_EN
    chk("pause_low", 32'(txq_low), 1);
`endif

    // Reset mid-frame discards the queue.
    step(); tx_en = 1'b1;
    wait_trmt(50, "rst_trmt");
    repeat (10) step();
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_level", 32'(level), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_empty", 32'(empty), 1);
    chk("midrst_trmt", 32'(trmt), 0);
    step(); rst_n = 1'b1; tx_en = 1'b0;
    @(negedge clk);
    chk("postrst_level", 32'(level), 0);
    chk("postrst_busy", 32'(busy), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
